// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin scheduler sharing one 4:1 mux lane between four requesters
//
// mux4to1: plain 4:1 single-bit multiplexer.
//   a, b, c, d : data inputs selected by sel = 0, 1, 2, 3
//   sel        : 2-bit select
//   y          : selected data bit
//
// mux4_rr_sched: grants one requester at a time for a burst of at most
// BURST_LEN cycles, then inserts a one-cycle release gap before
// re-arbitrating round-robin from the requester after the last winner.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : request vector, bit i = requester i
//   data_in : data bits, data_in[i] feeds mux input i
//   lock    : (only with MUX4_RR_SCHED_LOCK_EN) hold the current grant past BURST_LEN
//   grant   : one-hot grant, registered
//   select  : registered mux select, holds its value outside GRANT
//   busy    : high while in GRANT
//   y       : mux output gated by busy
//
// Optional feature macro: MUX4_RR_SCHED_LOCK_EN adds the lock input.

module mux4to1 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       y
);
    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end
endmodule

module mux4_rr_sched #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
`ifdef MUX4_RR_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       busy,
    output logic       y
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic             win_valid;
    logic [1:0]       win_idx;
    logic             at_limit;
    logic             stay;
    logic             mux_y;

    // Search ptr, ptr+1, ... ; iterating from the farthest offset down lets the
    // nearest requester overwrite the result last.
    always_comb begin
        logic [1:0] idx;
        win_valid = 1'b0;
        win_idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign at_limit = (cnt == BURST_MAX);

`ifdef MUX4_RR_SCHED_LOCK_EN
    // While locked the burst limit is ignored; only a dropped request ends it.
    assign stay = req[select] && (!at_limit || lock);
`else
    assign stay = req[select] && !at_limit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 4'b0000;
            select <= 2'b00;
            busy   <= 1'b0;
            ptr    <= 2'b00;
            cnt    <= '0;
        end else begin
            case (state)
                GRANT: begin
                    if (stay) begin
                        // Saturates at BURST_MAX (only reachable when locked).
                        if (!at_limit) begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end else begin
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        ptr   <= select + 2'd1;
                        state <= RELEASE;
                    end
                end
                default: begin
                    // IDLE and RELEASE arbitrate identically; RELEASE falls
                    // back to IDLE when nobody is requesting.
                    if (win_valid) begin
                        grant  <= 4'b0001 << win_idx;
                        select <= win_idx;
                        busy   <= 1'b1;
                        cnt    <= CNT_ONE;
                        state  <= GRANT;
                    end else begin
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    mux4to1 u_mux (
        .a   (data_in[0]),
        .b   (data_in[1]),
        .c   (data_in[2]),
        .d   (data_in[3]),
        .sel (select),
        .y   (mux_y)
    );

    assign y = mux_y & busy;

endmodule
